m_cmd_exec: RTL and testbench
=============================

# m_cmd_exec

Command executor sitting directly downstream of the UART frame decoder in the local-dimming control path. It samples each decoded command (code, length, parameter word, check byte) on the decoder's one-cycle valid strobe and validates it. Valid writes go into the dimming configuration registers. Every accepted command gets a 5-byte acknowledge frame back through a valid/ready byte interface to the UART transmitter.

## Interface
- GAIN_RST, 8'h80, reset value of o_gain
- THRESH_RST, 16'h0100, reset value of o_thresh
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_vaild  input  1  one-cycle strobe: command fields below are stable
- cmdcode  input  8  command code
- cmd_len  input  8  length byte = 1 (cmd) + number of parameter bytes
- i_para_list  input  32  parameters; first received byte in [7:0], second in [15:8], ...
- i_check  input  8  frame check/tail byte
- i_tx_ready  input  1  transmitter can take a byte this cycle
- o_tx_valid  output  1  response byte valid
- o_tx_data  output  8  response byte
- o_dim_en  output  1  local dimming enable
- o_dim_mode  output  2  dimming mode
- o_gain  output  8  backlight gain
- o_thresh  output  16  zone luminance threshold
- o_window  output  32  window config {y1,x1,y0,x0}
- o_cfg_upd  output  1  one-cycle pulse when a config register was written
- o_err_cnt  output  8  saturating count of rejected commands
- o_drop_cnt  output  8  saturating count of commands dropped while busy

## Operation
- States: IDLE, EXEC, SEND.
- IDLE with cmd_vaild=1: latch cmdcode, cmd_len, i_para_list, i_check; go to EXEC.
- cmd_vaild in EXEC or SEND: command ignored, o_drop_cnt += 1 (saturate at 255), no register write, no response.
- EXEC evaluates status in priority order:
  - i_check != 8'hBC -> 8'h01 (bad check)
  - unknown code -> 8'h02
  - cmd_len mismatch -> 8'h03
  - else 8'h00
- Command table (code: required cmd_len -> action):
  - 0x01: 2 -> o_dim_en <= para[0]
  - 0x02: 2 -> o_dim_mode <= para[1:0]
  - 0x03: 2 -> o_gain <= para[7:0]
  - 0x04: 3 -> o_thresh <= para[15:0]
  - 0x05: 5 -> o_window <= para[31:0]
  - 0x10: 1 -> no write; status-read ping
- Status 0x00 with codes 0x01–0x05: write the register and pulse o_cfg_upd. Code 0x10 does not pulse o_cfg_upd.
- Status != 0x00: registers unchanged; o_err_cnt += 1 (saturate at 255).
- EXEC always moves to SEND with byte index 0.
- SEND transmits the ack frame in order: 0x40, 0x02, latched cmdcode, status, 0xBC.
- Byte transfer occurs on a cycle with o_tx_valid=1 and i_tx_ready=1. Then the index advances and o_tx_data loads the next byte in the following cycle.
- o_tx_valid stays high and o_tx_data stays stable until the transfer.
- After the 0xBC transfer: o_tx_valid <= 0, state -> IDLE.

## Timing
- Reset values:
  - state IDLE
  - o_tx_valid 0, o_tx_data 0
  - o_dim_en 0, o_dim_mode 0
  - o_gain GAIN_RST, o_thresh THRESH_RST, o_window 0
  - o_cfg_upd 0, o_err_cnt 0, o_drop_cnt 0
- Reset asserted mid-frame abandons the response; no partial bytes follow the reset release.
- cmd_vaild high at edge T:
  - EXEC during cycle T+1.
  - Config register and o_cfg_upd visible after edge T+2.
  - o_tx_valid=1 with 0x40 visible after edge T+2.
- With i_tx_ready tied high:
  - One byte per cycle; 5 consecutive valid cycles.
  - Back in IDLE after edge T+7.
  - Earliest next accepted cmd_vaild is at edge T+7.
- i_tx_ready low stalls indefinitely with no byte loss or duplication.
- All counters and config registers are plain registers; no combinational path from inputs to outputs.

## Test plan
- Frame cmd 0x03, len 2, para 0x0000_0055, check 0xBC, ready high -> o_gain=0x55 and o_cfg_upd pulse at T+2; bytes 40 02 03 00 BC on 5 consecutive cycles.
- Cmd 0x04, len 3, para 0x0000_1234, check 0xBC, ready toggling 1-0-0-1... -> o_thresh=0x1234; each ack byte held stable through stalls; exactly 5 transfers.
- Cmd 0x01, check 0xAA -> no register change, no o_cfg_upd; ack 40 02 01 01 BC; o_err_cnt=1.
- Three errors: cmd 0x07 len 2 -> status 0x02; cmd 0x05 len 3 -> status 0x03; cmd 0x10 len 1 -> status 0x00 with no write. o_err_cnt=2 afterwards.
- Second cmd_vaild while SEND stalled (ready low) -> o_drop_cnt=1; only the first command's ack is sent and only its write applied.
- rst_n pulsed low during the 3rd ack byte -> all outputs return to reset values (o_gain=0x80, o_thresh=0x0100); o_tx_valid stays 0 until the next command.

Source files
------------

// File: rtl/m_cmd_exec.sv
// Command executor: validates decoded UART commands, writes the dimming config
// registers and returns a 5-byte acknowledge frame over a valid/ready byte port.
module m_cmd_exec #(
    parameter logic [7:0]  GAIN_RST   = 8'h80,
    parameter logic [15:0] THRESH_RST = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vaild,
    input  logic [7:0]  cmdcode,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] i_para_list,
    input  logic [7:0]  i_check,
    input  logic        i_tx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_dim_en,
    output logic [1:0]  o_dim_mode,
    output logic [7:0]  o_gain,
    output logic [15:0] o_thresh,
    output logic [31:0] o_window,
    output logic        o_cfg_upd,
    output logic [7:0]  o_err_cnt,
    output logic [7:0]  o_drop_cnt
);

    localparam logic [7:0] ACK_HDR  = 8'h40;
    localparam logic [7:0] ACK_LEN  = 8'h02;
    localparam logic [7:0] ACK_TAIL = 8'hBC;
    localparam logic [7:0] CHECK_OK = 8'hBC;
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        SEND = 2'd2
    } state_t;

    // Priority: check byte, then code lookup, then length.
    function automatic logic [7:0] eval_status(input logic [7:0] code,
                                               input logic [7:0] len,
                                               input logic [7:0] chk);
        logic       known;
        logic [7:0] req_len;
        known   = 1'b1;
        req_len = 8'd0;
        case (code)
            8'h01, 8'h02, 8'h03: req_len = 8'd2;
            8'h04:               req_len = 8'd3;
            8'h05:               req_len = 8'd5;
            8'h10:               req_len = 8'd1;
            default:             known   = 1'b0;
        endcase
        if (chk != CHECK_OK)
            eval_status = 8'h01;
        else if (!known)
            eval_status = 8'h02;
        else if (len != req_len)
            eval_status = 8'h03;
        else
            eval_status = 8'h00;
    endfunction

    function automatic logic [7:0] ack_byte(input logic [2:0] idx,
                                            input logic [7:0] code,
                                            input logic [7:0] status);
        case (idx)
            3'd0:    ack_byte = ACK_HDR;
            3'd1:    ack_byte = ACK_LEN;
            3'd2:    ack_byte = code;
            3'd3:    ack_byte = status;
            default: ack_byte = ACK_TAIL;
        endcase
    endfunction

    // Input capture stage: decoder fields are registered every cycle.
    logic        vld_in_q,   vld_in_d;
    logic [7:0]  code_in_q,  code_in_d;
    logic [7:0]  len_in_q,   len_in_d;
    logic [31:0] para_in_q,  para_in_d;
    logic [7:0]  check_in_q, check_in_d;

    // Command held for execution and acknowledge.
    state_t      state_q,    state_d;
    logic [7:0]  code_q,     code_d;
    logic [7:0]  len_q,      len_d;
    logic [31:0] para_q,     para_d;
    logic [7:0]  check_q,    check_d;
    logic [7:0]  status_q,   status_d;
    logic [2:0]  idx_q,      idx_d;

    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        dim_en_q,   dim_en_d;
    logic [1:0]  dim_mode_q, dim_mode_d;
    logic [7:0]  gain_q,     gain_d;
    logic [15:0] thresh_q,   thresh_d;
    logic [31:0] window_q,   window_d;
    logic        cfg_upd_q,  cfg_upd_d;
    logic [7:0]  err_cnt_q,  err_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic [7:0]  exec_status;
    logic        tx_fire;

    assign exec_status = eval_status(code_q, len_q, check_q);
    assign tx_fire     = tx_valid_q && i_tx_ready;

    always_comb begin
        vld_in_d   = cmd_vaild;
        code_in_d  = cmdcode;
        len_in_d   = cmd_len;
        para_in_d  = i_para_list;
        check_in_d = i_check;

        state_d    = state_q;
        code_d     = code_q;
        len_d      = len_q;
        para_d     = para_q;
        check_d    = check_q;
        status_d   = status_q;
        idx_d      = idx_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        dim_en_d   = dim_en_q;
        dim_mode_d = dim_mode_q;
        gain_d     = gain_q;
        thresh_d   = thresh_q;
        window_d   = window_q;
        cfg_upd_d  = 1'b0;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (vld_in_q) begin
                    code_d  = code_in_q;
                    len_d   = len_in_q;
                    para_d  = para_in_q;
                    check_d = check_in_q;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                status_d = exec_status;
                if (exec_status == 8'h00) begin
                    case (code_q)
                        8'h01: begin dim_en_d   = para_q[0];     cfg_upd_d = 1'b1; end
                        8'h02: begin dim_mode_d = para_q[1:0];   cfg_upd_d = 1'b1; end
                        8'h03: begin gain_d     = para_q[7:0];   cfg_upd_d = 1'b1; end
                        8'h04: begin thresh_d   = para_q[15:0];  cfg_upd_d = 1'b1; end
                        8'h05: begin window_d   = para_q;        cfg_upd_d = 1'b1; end
                        default: ;
                    endcase
                end else if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                idx_d      = 3'd0;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_HDR;
                state_d    = SEND;
            end
            SEND: begin
                // Next byte is loaded only after the current one is taken.
                if (tx_fire) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = ack_byte(idx_q + 3'd1, code_q, status_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (vld_in_q && (state_q != IDLE) && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_in_q   <= 1'b0;
            code_in_q  <= 8'h00;
            len_in_q   <= 8'h00;
            para_in_q  <= 32'h0;
            check_in_q <= 8'h00;
            state_q    <= IDLE;
            code_q     <= 8'h00;
            len_q      <= 8'h00;
            para_q     <= 32'h0;
            check_q    <= 8'h00;
            status_q   <= 8'h00;
            idx_q      <= 3'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            dim_en_q   <= 1'b0;
            dim_mode_q <= 2'd0;
            gain_q     <= GAIN_RST;
            thresh_q   <= THRESH_RST;
            window_q   <= 32'h0;
            cfg_upd_q  <= 1'b0;
            err_cnt_q  <= 8'h00;
            drop_cnt_q <= 8'h00;
        end else begin
            vld_in_q   <= vld_in_d;
            code_in_q  <= code_in_d;
            len_in_q   <= len_in_d;
            para_in_q  <= para_in_d;
            check_in_q <= check_in_d;
            state_q    <= state_d;
            code_q     <= code_d;
            len_q      <= len_d;
            para_q     <= para_d;
            check_q    <= check_d;
            status_q   <= status_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            dim_en_q   <= dim_en_d;
            dim_mode_q <= dim_mode_d;
            gain_q     <= gain_d;
            thresh_q   <= thresh_d;
            window_q   <= window_d;
            cfg_upd_q  <= cfg_upd_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_dim_en   = dim_en_q;
    assign o_dim_mode = dim_mode_q;
    assign o_gain     = gain_q;
    assign o_thresh   = thresh_q;
    assign o_window   = window_q;
    assign o_cfg_upd  = cfg_upd_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_m_cmd_exec.sv
// Bench for m_cmd_exec: directed frames plus random traffic, compared every cycle
// against a queue-based model of command acceptance, register writes and ack bytes.
module tb_m_cmd_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vaild = 1'b0;
    logic [7:0]  cmdcode = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic [31:0] i_para_list = 32'h0;
    logic [7:0]  i_check = 8'h00;
    logic        i_tx_ready = 1'b1;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        o_dim_en;
    logic [1:0]  o_dim_mode;
    logic [7:0]  o_gain;
    logic [15:0] o_thresh;
    logic [31:0] o_window;
    logic        o_cfg_upd;
    logic [7:0]  o_err_cnt;
    logic [7:0]  o_drop_cnt;

    m_cmd_exec dut (
        .clk(clk), .rst_n(rst_n), .cmd_vaild(cmd_vaild), .cmdcode(cmdcode),
        .cmd_len(cmd_len), .i_para_list(i_para_list), .i_check(i_check),
        .i_tx_ready(i_tx_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
        .o_dim_en(o_dim_en), .o_dim_mode(o_dim_mode), .o_gain(o_gain),
        .o_thresh(o_thresh), .o_window(o_window), .o_cfg_upd(o_cfg_upd),
        .o_err_cnt(o_err_cnt), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;
    bit quiet  = 1'b0;

    // Model state: pending execution countdown, bytes still owed, register image.
    int          m_pend;
    logic [7:0]  m_q[$];
    logic        m_drop_pend;
    logic [7:0]  f_code, f_len, f_chk;
    logic [31:0] f_para;
    logic        e_dim_en;
    logic [1:0]  e_dim_mode;
    logic [7:0]  e_gain, e_err, e_drop;
    logic [15:0] e_thresh;
    logic [31:0] e_window;
    logic        e_cfg_upd;

    logic [7:0]  seen[$];
    int          seen_cyc[$];
    logic [7:0]  codes[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h07, 8'hFF};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int req_len(input logic [7:0] code);
        case (code)
            8'h01, 8'h02, 8'h03: return 2;
            8'h04:               return 3;
            8'h05:               return 5;
            8'h10:               return 1;
            default:             return -1;
        endcase
    endfunction

    function automatic logic [7:0] spec_status(input logic [7:0] code, input logic [7:0] len,
                                               input logic [7:0] chk_b);
        if (chk_b != 8'hBC) return 8'h01;
        if (req_len(code) < 0) return 8'h02;
        if (int'(len) != req_len(code)) return 8'h03;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_q.delete(); m_drop_pend = 1'b0;
        e_dim_en = 1'b0; e_dim_mode = 2'd0; e_gain = 8'h80; e_thresh = 16'h0100;
        e_window = 32'h0; e_cfg_upd = 1'b0; e_err = 8'h00; e_drop = 8'h00;
    endtask

    task automatic model_exec();
        logic [7:0] st;
        st = spec_status(f_code, f_len, f_chk);
        if (st == 8'h00) begin
            case (f_code)
                8'h01: e_dim_en   = f_para[0];
                8'h02: e_dim_mode = f_para[1:0];
                8'h03: e_gain     = f_para[7:0];
                8'h04: e_thresh   = f_para[15:0];
                8'h05: e_window   = f_para;
                default: ;
            endcase
            if (f_code >= 8'h01 && f_code <= 8'h05) e_cfg_upd = 1'b1;
        end else if (e_err != 8'hFF) begin
            e_err = e_err + 8'd1;
        end
        m_q.push_back(8'h40); m_q.push_back(8'h02); m_q.push_back(f_code);
        m_q.push_back(st);    m_q.push_back(8'hBC);
    endtask

    // Predicts the effect of the coming clock edge given the inputs now driven.
    task automatic model_edge();
        e_cfg_upd = 1'b0;
        if (m_drop_pend) begin
            if (e_drop != 8'hFF) e_drop = e_drop + 8'd1;
            m_drop_pend = 1'b0;
        end
        if (m_q.size() > 0 && i_tx_ready) void'(m_q.pop_front());
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) model_exec();
        end
        if (cmd_vaild) begin
            if (m_pend == 0 && m_q.size() == 0) begin
                f_code = cmdcode; f_len = cmd_len; f_para = i_para_list; f_chk = i_check;
                m_pend = 2;
            end else begin
                m_drop_pend = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("tx_valid", o_tx_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("tx_data", o_tx_data, m_q[0]);
            chk("dim_en",   o_dim_en,   e_dim_en);
            chk("dim_mode", o_dim_mode, e_dim_mode);
            chk("gain",     o_gain,     e_gain);
            chk("thresh",   o_thresh,   e_thresh);
            chk("window",   o_window,   e_window);
            chk("cfg_upd",  o_cfg_upd,  e_cfg_upd);
            chk("err_cnt",  o_err_cnt,  e_err);
            chk("drop_cnt", o_drop_cnt, e_drop);
        end
    end

    task automatic step(input logic v, input logic [7:0] c, input logic [7:0] l,
                        input logic [31:0] p, input logic [7:0] k, input logic rdy);
        @(negedge clk);
        cyc++;
        cmd_vaild = v; cmdcode = c; cmd_len = l; i_para_list = p; i_check = k;
        i_tx_ready = rdy;
        if (v && !quiet)
            $display("cycle %0d: cmd code=%h len=%0d para=%h check=%h", cyc, c, l, p, k);
        if (rst_n && o_tx_valid && i_tx_ready) begin
            seen.push_back(o_tx_data);
            seen_cyc.push_back(cyc);
            if (!quiet) $display("cycle %0d: ack byte %h", cyc, o_tx_data);
        end
        if (rst_n) model_edge();
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       step(1'b0, 8'h00, 8'h00, 32'h0, 8'h00, 1'b1);
                1:       step(1'b0, 8'h00, 8'h00, 32'h0, 8'h00, (i % 3) == 0);
                2:       step(1'b0, 8'h00, 8'h00, 32'h0, 8'h00, 1'b0);
                default: step(1'b0, 8'h00, 8'h00, 32'h0, 8'h00, $urandom_range(0, 9) < 7);
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cmd_vaild = 1'b0; i_tx_ready = 1'b1;
        model_reset();
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_edge();
        seen.delete(); seen_cyc.delete();
    endtask

    task automatic expect_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] exp_b[5];
        exp_b = '{b0, b1, b2, b3, b4};
        chk({name, "_count"}, seen.size(), 5);
        for (int i = 0; i < 5; i++)
            chk(name, (i < seen.size()) ? {24'h0, seen[i]} : 32'hFFFF_FFFF, exp_b[i]);
    endtask

    initial begin
        int s;
        model_reset();
        do_reset();
        chk("rst_gain",   o_gain,     8'h80);
        chk("rst_thresh", o_thresh,   16'h0100);
        chk("rst_txv",    o_tx_valid, 1'b0);
        chk("rst_txd",    o_tx_data,  8'h00);
        chk("rst_err",    o_err_cnt,  8'h00);

        // Gain write with ready held high.
        step(1'b1, 8'h03, 8'd2, 32'h0000_0055, 8'hBC, 1'b1);
        s = cyc;
        idle(9, 0);
        chk("t1_gain", o_gain, 8'h55);
        expect_frame("t1_frame", 8'h40, 8'h02, 8'h03, 8'h00, 8'hBC);
        chk("t1_first_xfer", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, s + 3);
        for (int i = 1; i < seen_cyc.size(); i++)
            chk("t1_consecutive", seen_cyc[i], seen_cyc[0] + i);

        // Threshold write under a stalling transmitter.
        seen.delete(); seen_cyc.delete();
        step(1'b1, 8'h04, 8'd3, 32'h0000_1234, 8'hBC, 1'b1);
        idle(22, 1);
        chk("t2_thresh", o_thresh, 16'h1234);
        expect_frame("t2_frame", 8'h40, 8'h02, 8'h04, 8'h00, 8'hBC);

        // Bad check byte.
        seen.delete(); seen_cyc.delete();
        step(1'b1, 8'h01, 8'd2, 32'h0000_0001, 8'hAA, 1'b1);
        idle(9, 0);
        chk("t3_dim_en", o_dim_en, 1'b0);
        chk("t3_err", o_err_cnt, 8'd1);
        expect_frame("t3_frame", 8'h40, 8'h02, 8'h01, 8'h01, 8'hBC);

        // Unknown code, wrong length, status ping.
        do_reset();
        step(1'b1, 8'h07, 8'd2, 32'h0, 8'hBC, 1'b1); idle(9, 0);
        expect_frame("t4_unknown", 8'h40, 8'h02, 8'h07, 8'h02, 8'hBC);
        seen.delete(); seen_cyc.delete();
        step(1'b1, 8'h05, 8'd3, 32'hDEAD_BEEF, 8'hBC, 1'b1); idle(9, 0);
        expect_frame("t4_badlen", 8'h40, 8'h02, 8'h05, 8'h03, 8'hBC);
        seen.delete(); seen_cyc.delete();
        step(1'b1, 8'h10, 8'd1, 32'h0, 8'hBC, 1'b1); idle(9, 0);
        expect_frame("t4_ping", 8'h40, 8'h02, 8'h10, 8'h00, 8'hBC);
        chk("t4_err", o_err_cnt, 8'd2);
        chk("t4_window", o_window, 32'h0);

        // Second command arrives while the ack is stalled.
        do_reset();
        step(1'b1, 8'h03, 8'd2, 32'h0000_0011, 8'hBC, 1'b0);
        idle(4, 2);
        step(1'b1, 8'h03, 8'd2, 32'h0000_0022, 8'hBC, 1'b0);
        idle(4, 2);
        idle(12, 0);
        chk("t5_drop", o_drop_cnt, 8'd1);
        chk("t5_gain", o_gain, 8'h11);
        expect_frame("t5_frame", 8'h40, 8'h02, 8'h03, 8'h00, 8'hBC);

        // Reset while the third ack byte is on the port.
        seen.delete(); seen_cyc.delete();
        step(1'b1, 8'h04, 8'd3, 32'h0000_ABCD, 8'hBC, 1'b1);
        idle(4, 0);
        chk("t6_thresh_pre", o_thresh, 16'hABCD);
        do_reset();
        chk("t6_gain", o_gain, 8'h80);
        chk("t6_thresh", o_thresh, 16'h0100);
        chk("t6_txv", o_tx_valid, 1'b0);
        idle(10, 0);
        chk("t6_no_bytes", seen.size(), 0);

        // Random traffic.
        quiet = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [7:0] c, l, k;
                c = codes[$urandom_range(0, 7)];
                l = ($urandom_range(0, 3) != 0 && req_len(c) > 0) ? 8'(req_len(c))
                                                                   : 8'($urandom_range(0, 6));
                k = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'hBC;
                step(1'b1, c, l, $urandom, k, $urandom_range(0, 9) < 7);
            end else begin
                idle(1, 3);
            end
            if (i == 700) do_reset();
        end
        idle(12, 0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 8'h02, 8'd2, 32'h3, 8'h00, 1'b1);
            idle(8, 0);
        end
        chk("sat_err", o_err_cnt, 8'hFF);
        for (int i = 0; i < 300; i++)
            step(1'b1, 8'h10, 8'd1, 32'h0, 8'hBC, 1'b0);
        idle(12, 0);
        chk("sat_drop", o_drop_cnt, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
